swap_sort_ctrl: RTL and testbench
=================================

// Module: swap_sort_ctrl
// PURPOSE
//   In-place bubble-sort sequencer for swap_reg_file. Owns the reg file's read and swap ports.
//   Compares neighbouring entries through the read port and exchanges them with a one-cycle swap.
//   A host write port passes through to the reg file only while the controller is idle.
// PARAMETERS
//   ADDR_WIDTH  7  reg file address width
//   DATA_WIDTH  8  reg file data width; entries are compared as unsigned
// PORTS
//   clk          in   1         system clock, rising edge
//   reset_n      in   1         asynchronous active-low reset
//   start        in   1         1-cycle pulse; samples base_addr/len while idle
//   base_addr    in   ADDR_W    first entry of the region
//   len          in   ADDR_W+1  number of entries to sort
//   busy         out  1         high from the cycle after an accepted start until done
//   done         out  1         1-cycle pulse when the sort is complete
//   host_we      in   1         host write request
//   host_addr_w  in   ADDR_W    host write address
//   host_data_w  in   DATA_W    host write data
//   host_err     out  1         1-cycle pulse: host_we arrived while busy and was dropped
//   rf_we        out  1         to reg file we
//   rf_address_w out  ADDR_W    to reg file address_w
//   rf_data_w    out  DATA_W    to reg file data_w
//   rf_address_r out  ADDR_W    to reg file address_r
//   rf_data_r    in   DATA_W    from reg file data_r (combinational read)
//   rf_address_a out  ADDR_W    to reg file address_a
//   rf_address_b out  ADDR_W    to reg file address_b
//   rf_swap      out  1         to reg file swap; a 1-cycle high exchanges a/b at the next edge
// BEHAVIOUR
//   - Reset: state IDLE; busy, done, host_err, rf_swap = 0; all rf_* addresses = 0; rf_we = 0.
//   - IDLE: rf_we/addr_w/data_w = host_*, combinationally. start is accepted only in IDLE.
//     - Accepting start latches base and len and sets last = len-1.
//     - Entering SETUP, pass_swapped is cleared.
//   - SETUP:
//     - If len <= 1: go to FIN (no swaps).
//     - Otherwise j = 0 and go to RD_A.
//   - RD_A: rf_address_r = base+j; latch rf_data_r into a_val.
//   - RD_B: rf_address_r = base+j+1.
//     - Set need = (a_val > rf_data_r).
//     - Equal values are never swapped, so the sort is stable.
//   - EXEC: rf_address_a = base+j, rf_address_b = base+j+1; rf_swap = need.
//     - If need: set pass_swapped.
//     - If j+1 < last: j++ and go to RD_A.
//     - Else, if pass_swapped && last > 1: last--, clear pass_swapped, j = 0, go to RD_A.
//     - Else: go to FIN.
//   - Timing: 3 cycles per comparison; swap is held high exactly 1 cycle.
//   - FIN: done = 1 for one cycle; busy = 0 in the same cycle; then IDLE.
//   - busy = 1 in SETUP, RD_A, RD_B and EXEC.
//   - Address arithmetic wraps modulo 2^ADDR_WIDTH; len is clamped to 2^ADDR_WIDTH.
//   - While busy: rf_we is forced to 0. A host_we is dropped and host_err pulses the next cycle.
//   - start while busy is ignored; no error is flagged.
//   - Early exit: a pass with no swap ends the sort.
//     - An already-sorted region of N entries finishes after N-1 comparisons.
//   - reset_n low mid-sort: immediate return to IDLE. The region is left partially sorted;
//     the swap in flight is aborted, so no entry is ever duplicated.
// CONFIGURATION
//   SORT_DESCEND_EN
//     - Defined: need = (a_val < rf_data_r), giving descending order.
//     - Undefined: ascending order.
//     - Ports and timing are identical either way.
// TESTING
//   1. Reset: reset_n low for 2 ns -> busy=0, done=0, rf_swap=0, rf_we=0.
//   2. Host writes i to addr i for i = 20..29.
//      Then start, base=20, len=10 -> 9 comparisons, 0 swaps, done 29 cycles after start.
//   3. Write 5,4,3,2,1 to addr 40..44; start, base=40, len=5.
//      -> reading 40..44 gives 1,2,3,4,5; rf_swap pulsed 10 times.
//   4. Write 7,3,7,1 to addr 0..3; sort len=4 -> 1,3,7,7.
//      Then len=1 and len=0 -> done 2 cycles after start, no rf_swap.
//   5. Pulse host_we=1 during a sort -> rf_we stays 0, host_err pulses once, data unchanged.
//      A second start while busy is ignored.
//   6. Assert reset_n low in an EXEC cycle -> busy=0, rf_swap=0 immediately.
//      The region is still a permutation of its original values.
//      With SORT_DESCEND_EN, test 3 leaves 5,4,3,2,1 with 0 swaps.

Source files
------------

// File: rtl/swap_sort_ctrl.sv
// In-place bubble-sort sequencer driving a swap_reg_file's read/swap ports; host writes pass through when idle.
// Optional SORT_DESCEND_EN selects descending order (default ascending).
module swap_sort_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr_w,
  input  logic [DATA_WIDTH-1:0] host_data_w,
  output logic                  host_err,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_address_w,
  output logic [DATA_WIDTH-1:0] rf_data_w,
  output logic [ADDR_WIDTH-1:0] rf_address_r,
  input  logic [DATA_WIDTH-1:0] rf_data_r,
  output logic [ADDR_WIDTH-1:0] rf_address_a,
  output logic [ADDR_WIDTH-1:0] rf_address_b,
  output logic                  rf_swap
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_RD_A, S_RD_B, S_EXEC, S_FIN
  } state_t;

  localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_len, r_last, r_j;
  logic [DATA_WIDTH-1:0] r_a_val;
  logic                  r_need, r_pass_swapped, r_host_err;

  logic [ADDR_WIDTH:0]   w_len_clamp, w_j_next;
  logic [ADDR_WIDTH-1:0] w_addr_j, w_addr_j1;
  logic                  w_out_of_order, w_more, w_again;

  assign w_len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
  assign w_addr_j    = r_base + r_j[ADDR_WIDTH-1:0];
  assign w_addr_j1   = w_addr_j + ADDR_WIDTH'(1);
  assign w_j_next    = r_j + ONE_L;
  assign w_more      = (w_j_next < r_last);
  // The swap decided in this EXEC cycle counts toward the current pass.
  assign w_again     = (r_pass_swapped | r_need) && (r_last > ONE_L);

`ifdef SORT_DESCEND_EN
  assign w_out_of_order = (r_a_val < rf_data_r);
`else
  assign w_out_of_order = (r_a_val > rf_data_r);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SETUP;
      S_SETUP: w_next = (r_len <= ONE_L) ? S_FIN : S_RD_A;
      S_RD_A:  w_next = S_RD_B;
      S_RD_B:  w_next = S_EXEC;
      S_EXEC:  w_next = (w_more || w_again) ? S_RD_A : S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    rf_we        = 1'b0;
    rf_address_w = '0;
    rf_data_w    = '0;
    rf_address_r = '0;
    rf_address_a = '0;
    rf_address_b = '0;
    rf_swap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        rf_we        = host_we;
        rf_address_w = host_addr_w;
        rf_data_w    = host_data_w;
      end
      S_SETUP: busy = 1'b1;
      S_RD_A: begin
        busy         = 1'b1;
        rf_address_r = w_addr_j;
      end
      S_RD_B: begin
        busy         = 1'b1;
        rf_address_r = w_addr_j1;
      end
      S_EXEC: begin
        busy         = 1'b1;
        rf_address_a = w_addr_j;
        rf_address_b = w_addr_j1;
        rf_swap      = r_need;
      end
      S_FIN: begin
        done         = 1'b1;
        rf_we        = host_we;
        rf_address_w = host_addr_w;
        rf_data_w    = host_data_w;
      end
      default: ;
    endcase
  end

  assign host_err = r_host_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base         <= '0;
      r_len          <= '0;
      r_last         <= '0;
      r_j            <= '0;
      r_a_val        <= '0;
      r_need         <= 1'b0;
      r_pass_swapped <= 1'b0;
      r_host_err     <= 1'b0;
    end else begin
      r_host_err <= host_we & busy;
      case (r_state)
        S_IDLE: if (start) begin
          r_base         <= base_addr;
          r_len          <= w_len_clamp;
          r_last         <= w_len_clamp - ONE_L;
          r_pass_swapped <= 1'b0;
        end
        S_SETUP: r_j <= '0;
        S_RD_A:  r_a_val <= rf_data_r;
        S_RD_B:  r_need <= w_out_of_order;
        S_EXEC: begin
          if (w_more) begin
            r_j            <= w_j_next;
            r_pass_swapped <= r_pass_swapped | r_need;
          end else if (w_again) begin
            r_last         <= r_last - ONE_L;
            r_pass_swapped <= 1'b0;
            r_j            <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_swap_sort_ctrl.sv
// Self-checking bench for swap_sort_ctrl with a behavioural swap_reg_file and a result scoreboard.
module tb_swap_sort_ctrl;
  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 128;
`ifdef SORT_DESCEND_EN
  localparam bit DESC = 1'b1;
`else
  localparam bit DESC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done, host_err;
  logic          host_we;
  logic [AW-1:0] host_addr_w;
  logic [DW-1:0] host_data_w;
  logic          rf_we, rf_swap;
  logic [AW-1:0] rf_address_w, rf_address_r, rf_address_a, rf_address_b;
  logic [DW-1:0] rf_data_w, rf_data_r;

  swap_sort_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .host_we(host_we), .host_addr_w(host_addr_w),
    .host_data_w(host_data_w), .host_err(host_err), .rf_we(rf_we),
    .rf_address_w(rf_address_w), .rf_data_w(rf_data_w), .rf_address_r(rf_address_r),
    .rf_data_r(rf_data_r), .rf_address_a(rf_address_a), .rf_address_b(rf_address_b),
    .rf_swap(rf_swap)
  );

  always #5 clk = ~clk;

  // Behavioural reg file: combinational read, write and swap at the clock edge.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rf_we) mem[rf_address_w] <= rf_data_w;
    if (rf_swap) begin
      mem[rf_address_a] <= mem[rf_address_b];
      mem[rf_address_b] <= mem[rf_address_a];
    end
  end
  assign rf_data_r = mem[rf_address_r];

  int cyc = 0, swap_cnt = 0, err_cnt = 0, we_busy_cnt = 0;
  always @(posedge clk) begin
    cyc++;
    if (rf_swap) swap_cnt++;
  end
  always @(negedge clk) begin
    if (host_err) err_cnt++;
    if (busy && rf_we) we_busy_cnt++;
  end

  typedef struct { int lat; int swaps; int base; int len; } exp_t;
  exp_t sb[$];
  logic [DW-1:0] model [DEPTH];
  int n_cmp = 0, n_mis = 0;
  int t_start, s0, e0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input int d);
    host_we     = 1'b1;
    host_addr_w = AW'(a);
    host_data_w = DW'(d);
    tick();
    host_we     = 1'b0;
    model[a % DEPTH] = DW'(d);
  endtask

  function automatic bit wrong_order(input int x, input int y);
    return DESC ? (x < y) : (x > y);
  endfunction

  function automatic int inversions(input int base, input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      for (int k = i + 1; k < n; k++)
        if (wrong_order(model[(base+i)%DEPTH], model[(base+k)%DEPTH])) c++;
    return c;
  endfunction

  task automatic drive_start(input int base, input int n);
    start     = 1'b1;
    base_addr = AW'(base);
    len       = (AW+1)'(n);
    t_start   = cyc;
    s0        = swap_cnt;
    e0        = err_cnt;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
  endtask

  task automatic sort_start(input int base, input int n, input int lat_asc, input int lat_desc);
    exp_t e;
    int q[$];
    e.lat = DESC ? lat_desc : lat_asc;
    e.swaps = inversions(base, n);
    e.base = base;
    e.len = n;
    sb.push_back(e);
    for (int i = 0; i < n; i++) q.push_back(model[(base+i)%DEPTH]);
    if (DESC) q.rsort(); else q.sort();
    for (int i = 0; i < n; i++) model[(base+i)%DEPTH] = DW'(q[i]);
    drive_start(base, n);
  endtask

  task automatic wait_done;
    exp_t e;
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("latency", cyc - t_start, e.lat);
    check("swap_count", swap_cnt - s0, e.swaps);
    check("busy_at_done", busy, 0);
    tick();
    for (int i = 0; i < e.len; i++)
      check("region_data", mem[(e.base+i)%DEPTH], model[(e.base+i)%DEPTH]);
  endtask

  initial begin
    int vals[8];
    int q_got[$], q_ref[$];
    bit seen;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    host_we = 1'b0; host_addr_w = '0; host_data_w = '0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_swap", rf_swap, 0);
    check("rst_we", rf_we, 0);
    check("rst_addr_r", rf_address_r, 0);
    check("rst_host_err", host_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Already-sorted region: single pass, no swaps.
    for (int i = 20; i < 30; i++) host_write(i, i);
    sort_start(20, 10, 29, 137);
    wait_done();

    // Reversed region.
    for (int i = 0; i < 5; i++) host_write(40 + i, 5 - i);
    sort_start(40, 5, 32, 14);
    wait_done();

    // Duplicates, then degenerate lengths.
    host_write(0, 7); host_write(1, 3); host_write(2, 7); host_write(3, 1);
    sort_start(0, 4, 20, 17);
    wait_done();
    sort_start(0, 1, 2, 2);
    wait_done();
    sort_start(0, 0, 2, 2);
    wait_done();

    // Region wrapping past the top address.
    host_write(126, 4); host_write(127, 3); host_write(0, 2); host_write(1, 1);
    sort_start(126, 4, 20, 11);
    wait_done();

    // Host write and second start while busy must be dropped/ignored.
    for (int i = 0; i < 8; i++) host_write(60 + i, 8 - i);
    sort_start(60, 8, 86, 23);
    repeat (3) tick();
    host_we = 1'b1; host_addr_w = AW'(60); host_data_w = DW'(99);
    tick();
    host_we = 1'b0;
    @(negedge clk);
    check("host_err_next_cycle", host_err, 1);
    start = 1'b1; base_addr = '0; len = (AW+1)'(2);
    tick();
    start = 1'b0;
    wait_done();
    check("host_err_pulses", err_cnt - e0, 1);
    check("we_while_busy", we_busy_cnt, 0);
    repeat (3) tick();
    check("busy_after_ignored_start", busy, 0);

    // Reset during an EXEC cycle with a swap in flight.
    vals = '{9, 2, 6, 4, 8, 1, 7, 3};
    for (int i = 0; i < 8; i++) host_write(80 + i, vals[i]);
    drive_start(80, 8);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rf_swap) begin
        seen = 1'b1;
        break;
      end
    end
    check("swap_seen_before_abort", seen, 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_swap", rf_swap, 0);
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      q_got.push_back(mem[80 + i]);
      q_ref.push_back(vals[i]);
    end
    q_got.sort();
    q_ref.sort();
    for (int i = 0; i < 8; i++) check("abort_permutation", q_got[i], q_ref[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
